// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying one WIDTH-bit payload between pipeline stages.
interface pipe_stage_reg_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    // Producer side: offers valid/data, observes ready.
    modport master (
        output valid,
        output data,
        input  ready
    );

    // Consumer side: observes valid/data, returns ready.
    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: strict FIFO of up to two entries (SKID=1) or one
// entry (SKID=0), with hazard stall/flush controls and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      SKID       = 1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int unsigned      CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      up,
    pipe_stage_reg_if.master     dn,
    input  logic                 stall,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     hold_cycles
);

    localparam logic [CNT_W-1:0] HOLD_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             drain_c;
    logic             accept_c;
    logic             in_ready_c;

    // Handshake qualifiers; stall masks the downstream ready.
    always_comb begin
        drain_c = out_valid_q & dn.ready & ~stall;
        if (SKID != 0) begin
            // Registered decode: no path from in_valid, out_ready or stall.
            in_ready_c = in_ready_q;
        end else begin
            // Single entry can refill only in the cycle it is drained.
            in_ready_c = ~out_valid_q | drain_c;
        end
        accept_c = up.valid & in_ready_c;
    end

    // Next-state and entry movement; flush empties the stage and drops any input.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d = ST_ONE;
                        main_d  = up.data;
                    end
                end
                ST_ONE: begin
                    if (accept_c && drain_c) begin
                        main_d = up.data;
                    end else if (accept_c && (SKID != 0)) begin
                        // Back-pressure just appeared: park the new word behind main.
                        state_d = ST_TWO;
                        skid_d  = up.data;
                    end else if (drain_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain_c) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Registered output decode from the next state; empty stage presents the bubble.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        out_data_d  = (state_d == ST_EMPTY) ? BUBBLE_VAL : main_d;
        in_ready_d  = (state_d != ST_TWO);
    end

    // Saturating count of cycles where a valid output is not taken; flush cycles excluded.
    always_comb begin
        hold_d = hold_q;
        if (out_valid_q && !drain_c && !flush && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    // State and payload registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_data_q  <= BUBBLE_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            hold_q      <= hold_d;
        end
    end

    // Structural invariants of the entry bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (state_q != 2'd3);
            assert ((SKID != 0) || (state_q != ST_TWO));
            assert (out_valid_q == (state_q != ST_EMPTY));
            assert ((SKID == 0) || (in_ready_q == (state_q != ST_TWO)));
        end
    end

    assign up.ready    = in_ready_c;
    assign dn.valid    = out_valid_q;
    assign dn.data     = out_data_q;
    assign occupancy   = 2'(state_q);
    assign hold_cycles = hold_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table-driven vectors on a SKID=1 stage, hand sequences for
// SKID=0 combinational ready and counter saturation/reset, FIFO scoreboards on both stages.
module tb_pipe_stage_reg;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        stall;
    logic        flush;

    int n_cmp;
    int n_err;

    pipe_stage_reg_if #(.WIDTH(32)) up1 ();
    pipe_stage_reg_if #(.WIDTH(32)) dn1 ();
    pipe_stage_reg_if #(.WIDTH(32)) up0 ();
    pipe_stage_reg_if #(.WIDTH(32)) dn0 ();
    pipe_stage_reg_if #(.WIDTH(8))  ups ();
    pipe_stage_reg_if #(.WIDTH(8))  dns ();

    logic [1:0]  occ1, occ0, occs;
    logic [15:0] hold1, hold0;
    logic [1:0]  holds;

    assign up1.valid = in_valid;
    assign up1.data  = in_data;
    assign dn1.ready = out_ready;
    assign up0.valid = in_valid;
    assign up0.data  = in_data;
    assign dn0.ready = out_ready;
    assign ups.valid = in_valid;
    assign ups.data  = in_data[7:0];
    assign dns.ready = out_ready;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .BUBBLE_VAL(32'h0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .up(up1), .dn(dn1), .stall(stall), .flush(flush),
        .occupancy(occ1), .hold_cycles(hold1)
    );

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .BUBBLE_VAL(32'h0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .up(up0), .dn(dn0), .stall(stall), .flush(flush),
        .occupancy(occ0), .hold_cycles(hold0)
    );

    pipe_stage_reg #(.WIDTH(8), .SKID(1), .BUBBLE_VAL(8'hEE), .CNT_W(2)) u_duts (
        .clk(clk), .rst(rst), .up(ups), .dn(dns), .stall(stall), .flush(flush),
        .occupancy(occs), .hold_cycles(holds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        stl;
        logic        fl;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [1:0]  e_occ;
        logic [15:0] e_hold;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic stl, input logic fl, input logic e_ir,
                                input logic e_ov, input logic [31:0] e_od,
                                input logic [1:0] e_occ, input logic [15:0] e_hold);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.stl = stl; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ; v.e_hold = e_hold;
        return v;
    endfunction

    task automatic chk(input string nm, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s tag=%0d got=%0h expected=%0h", nm, tag, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic stl, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: words pushed on accept, popped and compared on drain.
    logic [31:0] q1[$];
    logic [31:0] q0[$];

    always @(negedge clk) begin : sb1
        logic [31:0] e;
        if (rst) begin
            q1.delete();
        end else begin
            if (dn1.valid && out_ready && !stall) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_err++;
                    $display("FAIL sb1_extra got=%0h expected=none", dn1.data);
                end else begin
                    e = q1.pop_front();
                    if (dn1.data !== e) begin
                        n_err++;
                        $display("FAIL sb1_data got=%0h expected=%0h", dn1.data, e);
                    end
                end
            end
            if (flush) q1.delete();
            else if (in_valid && up1.ready) q1.push_back(in_data);
        end
    end

    always @(negedge clk) begin : sb0
        logic [31:0] e;
        if (rst) begin
            q0.delete();
        end else begin
            if (dn0.valid && out_ready && !stall) begin
                n_cmp++;
                if (q0.size() == 0) begin
                    n_err++;
                    $display("FAIL sb0_extra got=%0h expected=none", dn0.data);
                end else begin
                    e = q0.pop_front();
                    if (dn0.data !== e) begin
                        n_err++;
                        $display("FAIL sb0_data got=%0h expected=%0h", dn0.data, e);
                    end
                end
            end
            if (flush) q0.delete();
            else if (in_valid && up0.ready) q0.push_back(in_data);
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset values on all three stages.
        @(negedge clk);
        chk("rst_ir1",   0, 32'(up1.ready),  32'h1);
        chk("rst_ov1",   0, 32'(dn1.valid),  32'h0);
        chk("rst_od1",   0, dn1.data,        32'h0);
        chk("rst_occ1",  0, 32'(occ1),       32'h0);
        chk("rst_hold1", 0, 32'(hold1),      32'h0);
        chk("rst_ir0",   0, 32'(up0.ready),  32'h1);
        chk("rst_ov0",   0, 32'(dn0.valid),  32'h0);
        chk("rst_ods",   0, 32'(dns.data),   32'hEE);
        chk("rst_ovs",   0, 32'(dns.valid),  32'h0);
        @(posedge clk);
        #1;

        // Stream, skid fill/release, stall, flush (SKID=1 stage).
        //              iv  data   or st fl  ir ov od     occ hold
        vecs.push_back(mk(1, 32'h11, 1, 0, 0, 1, 0, 32'h0,  0, 0));
        vecs.push_back(mk(1, 32'h22, 1, 0, 0, 1, 1, 32'h11, 1, 0));
        vecs.push_back(mk(1, 32'h33, 1, 0, 0, 1, 1, 32'h22, 1, 0));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 1, 32'h33, 1, 0));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 0));
        vecs.push_back(mk(1, 32'hA,  0, 0, 0, 1, 0, 32'h0,  0, 0));
        vecs.push_back(mk(1, 32'hB,  0, 0, 0, 1, 1, 32'hA,  1, 0));
        vecs.push_back(mk(1, 32'hC,  0, 0, 0, 0, 1, 32'hA,  2, 1));
        vecs.push_back(mk(1, 32'hC,  1, 0, 0, 0, 1, 32'hA,  2, 2));
        vecs.push_back(mk(1, 32'hC,  1, 0, 0, 1, 1, 32'hB,  1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 1, 32'hC,  1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 2));
        vecs.push_back(mk(1, 32'h5,  1, 0, 0, 1, 0, 32'h0,  0, 2));
        vecs.push_back(mk(0, 32'h0,  1, 1, 0, 1, 1, 32'h5,  1, 2));
        vecs.push_back(mk(0, 32'h0,  1, 1, 0, 1, 1, 32'h5,  1, 3));
        vecs.push_back(mk(0, 32'h0,  1, 1, 0, 1, 1, 32'h5,  1, 4));
        vecs.push_back(mk(0, 32'h0,  1, 1, 0, 1, 1, 32'h5,  1, 5));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 1, 32'h5,  1, 6));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 6));
        vecs.push_back(mk(1, 32'h1,  0, 0, 0, 1, 0, 32'h0,  0, 6));
        vecs.push_back(mk(1, 32'h2,  0, 0, 0, 1, 1, 32'h1,  1, 6));
        vecs.push_back(mk(1, 32'h3,  0, 0, 1, 0, 1, 32'h1,  2, 7));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 7));
        vecs.push_back(mk(1, 32'h4,  0, 0, 0, 1, 0, 32'h0,  0, 7));
        vecs.push_back(mk(1, 32'h3,  0, 0, 1, 1, 1, 32'h4,  1, 7));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 7));
        vecs.push_back(mk(1, 32'h6,  1, 0, 0, 1, 0, 32'h0,  0, 7));
        vecs.push_back(mk(0, 32'h0,  1, 0, 1, 1, 1, 32'h6,  1, 7));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 7));
        vecs.push_back(mk(0, 32'h0,  1, 0, 0, 1, 0, 32'h0,  0, 7));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].stl, vecs[i].fl);
            @(negedge clk);
            chk("tbl_ir",   i, 32'(up1.ready), 32'(vecs[i].e_ir));
            chk("tbl_ov",   i, 32'(dn1.valid), 32'(vecs[i].e_ov));
            chk("tbl_od",   i, dn1.data,       vecs[i].e_od);
            chk("tbl_occ",  i, 32'(occ1),      32'(vecs[i].e_occ));
            chk("tbl_hold", i, 32'(hold1),     32'(vecs[i].e_hold));
            @(posedge clk);
            #1;
        end
        chk("sb1_left", 0, 32'(q1.size()), 32'h0);

        // SKID=0: one word per cycle, combinational in_ready.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_ir", 0, 32'(up0.ready), 32'h1);
        step();
        drive(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_ov", 1, 32'(dn0.valid), 32'h1);
        chk("s0_od", 1, dn0.data,       32'h7);
        chk("s0_ir", 1, 32'(up0.ready), 32'h1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_ov", 2, 32'(dn0.valid), 32'h1);
        chk("s0_od", 2, dn0.data,       32'h8);
        step();
        drive(1'b1, 32'h9, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_ov", 3, 32'(dn0.valid), 32'h0);
        step();
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        #1;
        chk("s0_ir",  4, 32'(up0.ready), 32'h0);
        chk("s0_od",  4, dn0.data,       32'h9);
        chk("s0_occ", 4, 32'(occ0),      32'h1);
        out_ready = 1'b1;
        #1;
        chk("s0_ir_same", 4, 32'(up0.ready), 32'h1);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_od", 5, dn0.data, 32'hA);
        step();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("s0_ov",  6, 32'(dn0.valid), 32'h0);
        chk("s0_occ", 6, 32'(occ0),      32'h0);
        chk("sb0_left", 6, 32'(q0.size()), 32'h0);

        // Counter saturation at CNT_W=2, then reset with two entries held.
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h41, 1'b0, 1'b0, 1'b0);
        #1;
        chk("z_ov", 0, 32'(dns.valid), 32'h0);
        chk("z_od", 0, 32'(dns.data),  32'hEE);
        step();
        drive(1'b1, 32'h42, 1'b0, 1'b0, 1'b0);
        #1;
        chk("z_od", 1, 32'(dns.data), 32'h41);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            step();
        end
        #1;
        chk("z_hold", 2, 32'(holds),     32'h3);
        chk("z_occ",  2, 32'(occs),      32'h2);
        chk("z_od",   2, 32'(dns.data),  32'h41);
        chk("z_ir",   2, 32'(ups.ready), 32'h0);
        drive(1'b1, 32'h43, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("zr_ov",   3, 32'(dns.valid), 32'h0);
        chk("zr_od",   3, 32'(dns.data),  32'hEE);
        chk("zr_occ",  3, 32'(occs),      32'h0);
        chk("zr_hold", 3, 32'(holds),     32'h0);
        chk("zr_ir",   3, 32'(ups.ready), 32'h1);
        chk("zr_ov1",  3, 32'(dn1.valid), 32'h0);
        chk("zr_od1",  3, dn1.data,       32'h0);
        chk("zr_hold1", 3, 32'(hold1),    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register, the generalised successor to the fixed-field stage registers between the core's pipeline stages. It carries a WIDTH-bit payload with valid/ready handshaking, and keeps the legacy stall and flush controls driven by the hazard unit. With SKID=1 it adds a second skid entry so that in_ready is purely registered at full throughput. A saturating counter records back-pressure cycles for performance measurement.

## Interface
- WIDTH, 32: payload width in bits (≥1).
- SKID, 1: 1 = two-entry elastic stage with registered in_ready; 0 = single entry with combinational in_ready.
- BUBBLE_VAL, 0: payload driven whenever the stage holds no valid entry (NOP encoding).
- CNT_W, 16: width of the hold-cycle counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers in_data.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data is a valid entry.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  oldest held entry, or BUBBLE_VAL when empty.
- stall  in  1  hazard hold; acts as out_ready forced low.
- flush  in  1  discard all held entries and any same-cycle input.
- occupancy  out  2  entries held (0..2; never exceeds 1 when SKID=0).
- hold_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and drain=0.

## Operation
- Definitions:
  - accept = in_valid & in_ready
  - drain = out_valid & out_ready & ~stall
- Ordering is strict FIFO. No payload is duplicated or lost, except through flush.
- SKID=1 state machine:
  - States: EMPTY (occ 0), ONE (main valid), TWO (main and skid valid).
  - EMPTY: accept -> ONE, main <= in_data.
  - ONE:
    - accept & ~drain -> TWO, skid <= in_data.
    - drain & ~accept -> EMPTY.
    - accept & drain -> ONE, main <= in_data.
    - Otherwise hold.
  - TWO: in_ready = 0, so no accept is possible. drain -> ONE, main <= skid. Otherwise hold.
  - in_ready = (state != TWO). It is a registered decode, with no combinational path from out_ready, stall or in_valid.
- SKID=0:
  - in_ready = ~out_valid | drain (combinational).
  - accept loads main and sets valid. drain without accept clears valid.
- flush:
  - Highest priority after rst.
  - Next state is EMPTY and any accepting input is dropped.
  - in_ready is not forced low during the flush cycle; the offered word is simply discarded.
- out_data:
  - Registered; equals the main entry while valid.
  - Equals BUBBLE_VAL in the cycle after any transition to EMPTY (drain, flush or rst). Skid contents are never visible at out_data until moved to main.
- hold_cycles:
  - Increments when out_valid & ~drain & ~flush.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- occupancy: equals the state encoding (0/1/2).

## Timing
- Reset (rst=1 at an edge) gives:
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0, hold_cycles=0.
  - in_ready=1 for SKID=1. For SKID=0, in_ready=1 also follows from out_valid=0.
- Latency: a word accepted at edge N is on out_data with out_valid=1 after edge N, i.e. one cycle.
- Throughput:
  - One word per cycle for both SKID values while out_ready=1 and stall=0.
  - SKID=1 absorbs exactly one extra word when back-pressure appears.
- Back-pressure release:
  - In TWO, in_ready returns to 1 in the cycle after the first drain.
  - The skid word reaches out_data in that same cycle.
- Simultaneous events:
  - rst overrides flush; flush overrides accept and drain.
  - stall=1 with out_ready=1 counts as no drain.
  - A flush in the same cycle as a drain: downstream has still consumed the current output, and the stage empties.
- Mid-operation reset behaves the same as power-on reset. No partial entries survive.

## Test plan
- Stream: SKID=1, WIDTH=32, words 0x11,0x22,0x33 on consecutive cycles with out_ready=1 -> out_valid high for 3 cycles starting 1 cycle later, data 0x11,0x22,0x33, occupancy stays 1, hold_cycles=0.
- Skid fill: SKID=1, out_ready=0, offer 0xA then 0xB then 0xC -> 0xA and 0xB accepted, occupancy=2, in_ready=0 while 0xC is held upstream. Raise out_ready -> outputs 0xA,0xB,0xC in order, no gaps.
- Stall: occupancy 1 holding 0x5, stall=1 for 4 cycles with out_ready=1 -> out_data stays 0x5, hold_cycles=4. Release -> 0x5 consumed once.
- Flush: occupancy 2 (0x1,0x2), flush=1 while in_valid=1 with 0x3 -> next cycle out_valid=0, out_data=BUBBLE_VAL, occupancy=0; 0x3 never appears.
- SKID=0 pass-through: out_ready=1, consecutive words 0x7,0x8 -> one per cycle. With out_ready=0 and valid held, in_ready=0 combinationally. Raising out_ready in a cycle -> in_ready=1 in that same cycle.
- Reset/saturation: CNT_W=2, hold 6 cycles -> hold_cycles=3. Assert rst with occupancy 2 -> all outputs at their reset values next cycle.
